// File: rtl/rvc_asap_cr_ctrl_pkg.sv
// rtl/rvc_asap_cr_ctrl_pkg.sv - CR window offsets and flop macro for the rvc_asap CR block
// Purpose: shared register-map constants for rvc_asap_cr_ctrl and its sub-module.
// Ports: none (package).
`ifndef RVC_MSFF
`define RVC_MSFF(q, d, clk, rst) always_ff @(posedge clk or posedge rst) if (rst) q <= '0; else q <= d;
`endif

package rvc_asap_pkg;
  localparam int CR_WIN_BITS = 8;

  localparam logic [7:0] CR_SEG7_BASE = 8'h00;
  localparam logic [7:0] CR_LED       = 8'h40;
  localparam logic [7:0] CR_CURSOR_H  = 8'h44;
  localparam logic [7:0] CR_CURSOR_V  = 8'h48;
  localparam logic [7:0] CR_BTN       = 8'h50;
  localparam logic [7:0] CR_SWITCH    = 8'h54;
  localparam logic [7:0] CR_BTN_EVT   = 8'h58;
  localparam logic [7:0] CR_IRQ_MASK  = 8'h5C;
  localparam logic [7:0] CR_TIMER     = 8'h60;
  localparam logic [7:0] CR_TIMER_CMP = 8'h64;
  localparam logic [7:0] CR_STATUS    = 8'h68;
endpackage

// File: rtl/rvc_asap_cr_debounce.sv
// rtl/rvc_asap_cr_debounce.sv - 2-FF synchroniser plus counter debouncer for one button
// Purpose: accept a new button level only after CNT_MAX consecutive disagreeing cycles.
// Ports: Clock, Rst (async high) | RawIn raw async level | Stable debounced level |
//        RiseP one-cycle pulse coinciding with the edge where Stable goes 0->1.
`ifndef RVC_MSFF
`define RVC_MSFF(q, d, clk, rst) always_ff @(posedge clk or posedge rst) if (rst) q <= '0; else q <= d;
`endif

module rvc_asap_cr_debounce #(
  parameter int CNT_MAX = 50000
) (
  input  logic Clock,
  input  logic Rst,
  input  logic RawIn,
  output logic Stable,
  output logic RiseP
);
  localparam int CNT_W = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  logic             w_diff;
  logic             w_done;
  logic             w_stable_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Counter restarts whenever the synced level agrees with the accepted one,
  // so any pulse shorter than CNT_MAX cycles never reaches the terminal count.
  assign w_diff       = (r_sync2 != r_stable);
  assign w_done       = w_diff && (r_cnt == CNT_W'(CNT_MAX - 1));
  assign w_cnt_nxt    = (!w_diff || w_done) ? '0 : r_cnt + CNT_W'(1);
  assign w_stable_nxt = w_done ? r_sync2 : r_stable;

  `RVC_MSFF(r_sync1, RawIn, Clock, Rst)
  `RVC_MSFF(r_sync2, r_sync1, Clock, Rst)
  `RVC_MSFF(r_stable, w_stable_nxt, Clock, Rst)
  `RVC_MSFF(r_cnt, w_cnt_nxt, Clock, Rst)

  assign Stable = r_stable;
  // Combinational so the event register sets on the same edge Stable rises.
  assign RiseP  = w_done & r_sync2;
endmodule

// File: rtl/rvc_asap_cr_ctrl.sv
// rtl/rvc_asap_cr_ctrl.sv - memory-mapped control registers, timer and IRQ for the rvc_asap core
// Purpose: decodes core Q103H loads/stores into a 256B CR window and drives FPGA I/O.
// Ports: Clock, Rst (async high) | RegRdData2, AluOut, CtrlCRMemWrEn, SelCRMemWb (Q103H access) |
//        CRMemRdDataQ104H load data | Button, Switch raw inputs | SEG7, LED, IrqOut outputs.
module rvc_asap_cr_ctrl
  import rvc_asap_pkg::*;
#(
  parameter int          NUM_SEG7     = 6,
  parameter int          LED_W        = 10,
  parameter int          SW_W         = 10,
  parameter int          NUM_BTN      = 2,
  parameter int          DEBOUNCE_CYC = 50000,
  parameter logic [31:0] CR_BASE      = 32'h0000_C000
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [31:0]           RegRdData2,
  input  logic [31:0]           AluOut,
  input  logic                  CtrlCRMemWrEn,
  input  logic                  SelCRMemWb,
  output logic [31:0]           CRMemRdDataQ104H,
  input  logic [NUM_BTN-1:0]    Button,
  input  logic [SW_W-1:0]       Switch,
  output logic [NUM_SEG7*8-1:0] SEG7,
  output logic [LED_W-1:0]      LED,
  output logic                  IrqOut
);
  logic [NUM_SEG7*8-1:0] r_seg7;
  logic [LED_W-1:0]      r_led;
  logic [31:0]           r_cur_h;
  logic [31:0]           r_cur_v;
  logic [SW_W-1:0]       r_sw_s1;
  logic [SW_W-1:0]       r_sw_s2;
  logic [NUM_BTN-1:0]    r_btn_evt;
  logic [NUM_BTN:0]      r_irq_mask;
  logic [31:0]           r_timer;
  logic [31:0]           r_timer_cmp;
  logic                  r_status;
  logic                  r_irq;
  logic [31:0]           r_rd_data;

  logic                  w_hit;
  logic [7:0]            w_off;
  logic                  w_wr;
  logic [NUM_BTN-1:0]    w_btn_stable;
  logic [NUM_BTN-1:0]    w_btn_rise;
  logic [NUM_SEG7*8-1:0] w_seg7_nxt;
  logic [LED_W-1:0]      w_led_nxt;
  logic [31:0]           w_cur_h_nxt;
  logic [31:0]           w_cur_v_nxt;
  logic [NUM_BTN-1:0]    w_btn_evt_nxt;
  logic [NUM_BTN:0]      w_irq_mask_nxt;
  logic [31:0]           w_timer_nxt;
  logic [31:0]           w_timer_rd;
  logic [31:0]           w_timer_cmp_nxt;
  logic                  w_status_nxt;
  logic [31:0]           w_rd;
  logic                  w_unused;

  assign w_hit    = (AluOut[31:CR_WIN_BITS] == CR_BASE[31:CR_WIN_BITS]);
  assign w_off    = {AluOut[7:2], 2'b00};
  assign w_wr     = CtrlCRMemWrEn & w_hit;
  assign w_unused = ^{AluOut[1:0], RegRdData2};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      rvc_asap_cr_debounce #(.CNT_MAX(DEBOUNCE_CYC)) u_deb (
        .Clock  (Clock),
        .Rst    (Rst),
        .RawIn  (Button[g]),
        .Stable (w_btn_stable[g]),
        .RiseP  (w_btn_rise[g])
      );
    end
  endgenerate

  // Next-state for every register; the read mux reuses these so a load in the
  // same cycle as a store (or a W1C/set) sees the post-update value.
  always_comb begin
    w_seg7_nxt      = r_seg7;
    w_led_nxt       = r_led;
    w_cur_h_nxt     = r_cur_h;
    w_cur_v_nxt     = r_cur_v;
    w_irq_mask_nxt  = r_irq_mask;
    w_timer_cmp_nxt = r_timer_cmp;
    w_timer_rd      = r_timer;
    w_timer_nxt     = r_timer + 32'd1;
    w_btn_evt_nxt   = r_btn_evt;
    w_status_nxt    = r_status;
    if (w_wr) begin
      for (int i = 0; i < NUM_SEG7; i++) begin
        if (w_off == CR_SEG7_BASE + 8'(4 * i)) w_seg7_nxt[8*i +: 8] = RegRdData2[7:0];
      end
      case (w_off)
        CR_LED:       w_led_nxt       = RegRdData2[LED_W-1:0];
        CR_CURSOR_H:  w_cur_h_nxt     = RegRdData2;
        CR_CURSOR_V:  w_cur_v_nxt     = RegRdData2;
        CR_IRQ_MASK:  w_irq_mask_nxt  = RegRdData2[NUM_BTN:0];
        CR_TIMER_CMP: w_timer_cmp_nxt = RegRdData2;
        CR_TIMER: begin
          w_timer_nxt = RegRdData2;
          w_timer_rd  = RegRdData2;
        end
        CR_BTN_EVT:   w_btn_evt_nxt   = r_btn_evt & ~RegRdData2[NUM_BTN-1:0];
        CR_STATUS:    w_status_nxt    = r_status & ~RegRdData2[0];
        default:      ;
      endcase
    end
    // Sets applied after clears so a same-cycle event always survives.
    w_btn_evt_nxt = w_btn_evt_nxt | w_btn_rise;
    if (r_timer == r_timer_cmp) w_status_nxt = 1'b1;
  end

  always_comb begin
    w_rd = '0;
    if (SelCRMemWb && w_hit) begin
      case (w_off)
        CR_LED:       w_rd = 32'(w_led_nxt);
        CR_CURSOR_H:  w_rd = w_cur_h_nxt;
        CR_CURSOR_V:  w_rd = w_cur_v_nxt;
        CR_BTN:       w_rd = 32'(w_btn_stable);
        CR_SWITCH:    w_rd = 32'(r_sw_s2);
        CR_BTN_EVT:   w_rd = 32'(w_btn_evt_nxt);
        CR_IRQ_MASK:  w_rd = 32'(w_irq_mask_nxt);
        CR_TIMER:     w_rd = w_timer_rd;
        CR_TIMER_CMP: w_rd = w_timer_cmp_nxt;
        CR_STATUS:    w_rd = {31'd0, w_status_nxt};
        default: begin
          for (int i = 0; i < NUM_SEG7; i++) begin
            if (w_off == CR_SEG7_BASE + 8'(4 * i)) w_rd = {24'd0, w_seg7_nxt[8*i +: 8]};
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      r_seg7      <= '0;
      r_led       <= '0;
      r_cur_h     <= '0;
      r_cur_v     <= '0;
      r_sw_s1     <= '0;
      r_sw_s2     <= '0;
      r_btn_evt   <= '0;
      r_irq_mask  <= '0;
      r_timer     <= '0;
      r_timer_cmp <= '0;
      r_status    <= 1'b0;
      r_irq       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_seg7      <= w_seg7_nxt;
      r_led       <= w_led_nxt;
      r_cur_h     <= w_cur_h_nxt;
      r_cur_v     <= w_cur_v_nxt;
      r_sw_s1     <= Switch;
      r_sw_s2     <= r_sw_s1;
      r_btn_evt   <= w_btn_evt_nxt;
      r_irq_mask  <= w_irq_mask_nxt;
      r_timer     <= w_timer_nxt;
      r_timer_cmp <= w_timer_cmp_nxt;
      r_status    <= w_status_nxt;
      r_irq       <= |({r_status, r_btn_evt} & r_irq_mask);
      r_rd_data   <= w_rd;
    end
  end

  assign CRMemRdDataQ104H = r_rd_data;
  assign SEG7             = r_seg7;
  assign LED              = r_led;
  assign IrqOut           = r_irq;
endmodule

// File: tb/tb_rvc_asap_cr_ctrl.sv
// tb/tb_rvc_asap_cr_ctrl.sv - scoreboard bench for rvc_asap_cr_ctrl
module tb_rvc_asap_cr_ctrl;
  localparam int NUM_SEG7 = 6;
  localparam int LED_W    = 10;
  localparam int SW_W     = 10;
  localparam int NUM_BTN  = 2;

  logic                  Clock = 1'b0;
  logic                  Rst = 1'b1;
  logic [31:0]           RegRdData2 = '0;
  logic [31:0]           AluOut = '0;
  logic                  CtrlCRMemWrEn = 1'b0;
  logic                  SelCRMemWb = 1'b0;
  logic [31:0]           CRMemRdDataQ104H;
  logic [NUM_BTN-1:0]    Button = '0;
  logic [SW_W-1:0]       Switch = '0;
  logic [NUM_SEG7*8-1:0] SEG7;
  logic [LED_W-1:0]      LED;
  logic                  IrqOut;

  rvc_asap_cr_ctrl #(
    .NUM_SEG7(NUM_SEG7), .LED_W(LED_W), .SW_W(SW_W), .NUM_BTN(NUM_BTN),
    .DEBOUNCE_CYC(4), .CR_BASE(32'h0000_C000)
  ) dut (
    .Clock(Clock), .Rst(Rst), .RegRdData2(RegRdData2), .AluOut(AluOut),
    .CtrlCRMemWrEn(CtrlCRMemWrEn), .SelCRMemWb(SelCRMemWb),
    .CRMemRdDataQ104H(CRMemRdDataQ104H), .Button(Button), .Switch(Switch),
    .SEG7(SEG7), .LED(LED), .IrqOut(IrqOut)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic ld_pend = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a load seen at a rising edge presents data on Q104H after it.
  always @(posedge Clock) ld_pend <= SelCRMemWb;

  always @(negedge Clock) begin
    if (ld_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got 0x%0h expected no load", CRMemRdDataQ104H);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, 64'(CRMemRdDataQ104H), 64'(e.exp));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    AluOut = addr;
    RegRdData2 = data;
    CtrlCRMemWrEn = 1'b1;
    @(posedge Clock);
    #1;
    CtrlCRMemWrEn = 1'b0;
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp = exp;
    exp_q.push_back(e);
    AluOut = addr;
    SelCRMemWb = 1'b1;
    @(posedge Clock);
    #1;
    SelCRMemWb = 1'b0;
  endtask

  task automatic wrld(input string name, input logic [31:0] addr, input logic [31:0] data,
                      input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp = exp;
    exp_q.push_back(e);
    AluOut = addr;
    RegRdData2 = data;
    CtrlCRMemWrEn = 1'b1;
    SelCRMemWb = 1'b1;
    @(posedge Clock);
    #1;
    CtrlCRMemWrEn = 1'b0;
    SelCRMemWb = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge Clock);
    #1;
    Rst = 1'b0;
    check("rst_seg7", 64'(SEG7), 64'd0);
    check("rst_led", 64'(LED), 64'd0);
    check("rst_irq", 64'(IrqOut), 64'd0);
    check("rst_rdata", 64'(CRMemRdDataQ104H), 64'd0);

    wr(32'hC004, 32'h1234_56A5);
    check("seg7_digit1", 64'(SEG7), 64'h0000_0000_A500);
    ld("seg7_rd", 32'hC004, 32'h0000_00A5);
    ld("seg7_oob_rd", 32'hC018, 32'h0);
    wr(32'hC018, 32'h0000_00FF);
    check("seg7_oob_wr", 64'(SEG7), 64'h0000_0000_A500);

    wrld("led_wthru", 32'hC040, 32'hFFFF_FFFF, 32'h0000_03FF);
    check("led_out", 64'(LED), 64'h3FF);
    wr(32'hC044, 32'hDEAD_BEEF);
    ld("cursor_h", 32'hC044, 32'hDEAD_BEEF);

    Switch = 10'h2AA;
    idle(2);
    ld("switch", 32'hC054, 32'h0000_02AA);

    wr(32'hC060, 32'h0000_0100);
    ld("timer_a", 32'hC060, 32'h0000_0100);
    ld("timer_b", 32'hC060, 32'h0000_0101);

    // Short pulse of 3 cycles is filtered.
    Button = 2'b01;
    idle(3);
    Button = 2'b00;
    idle(10);
    ld("btn_short_evt", 32'hC058, 32'h0);
    ld("btn_short_lvl", 32'hC050, 32'h0);

    // Long press: event appears on the 6th edge after the raw rise.
    Button = 2'b01;
    idle(4);
    ld("btn_evt_early", 32'hC058, 32'h0);
    ld("btn_evt_set", 32'hC058, 32'h1);
    ld("btn_lvl_high", 32'hC050, 32'h1);
    idle(4);
    Button = 2'b00;
    idle(10);
    ld("btn_evt_sticky", 32'hC058, 32'h1);
    wr(32'hC058, 32'h1);
    ld("btn_evt_w1c", 32'hC058, 32'h0);
    ld("btn_lvl_low", 32'hC050, 32'h0);

    // W1C on the same edge as a new rise: set wins.
    Button = 2'b01;
    idle(5);
    wr(32'hC058, 32'h1);
    ld("btn_evt_setwins", 32'hC058, 32'h1);

    // Timer compare across the wrap.
    wr(32'hC064, 32'h1);
    wr(32'hC068, 32'h1);
    wr(32'hC05C, 32'h4);
    idle(2);
    check("irq_masked_off", 64'(IrqOut), 64'd0);
    ld("irq_mask_rd", 32'hC05C, 32'h4);
    wr(32'hC060, 32'hFFFF_FFFE);
    ld("timer_fffe", 32'hC060, 32'hFFFF_FFFE);
    ld("timer_ffff", 32'hC060, 32'hFFFF_FFFF);
    ld("timer_wrap", 32'hC060, 32'h0);
    ld("status_set", 32'hC068, 32'h1);
    check("irq_before", 64'(IrqOut), 64'd0);
    idle(1);
    check("irq_timer", 64'(IrqOut), 64'd1);
    wr(32'hC068, 32'h1);
    idle(1);
    check("irq_cleared", 64'(IrqOut), 64'd0);

    // Accesses outside the map.
    wr(32'hC0FC, 32'h1);
    wr(32'hD040, 32'h1);
    check("unmapped_led", 64'(LED), 64'h3FF);
    check("unmapped_seg7", 64'(SEG7), 64'h0000_0000_A500);
    ld("unmapped_rd", 32'hC0FC, 32'h0);
    ld("outside_rd", 32'hD040, 32'h0);
    ld("led_after", 32'hC040, 32'h0000_03FF);

    idle(3);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending_loads: got %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
